debug_seg_display: RTL and testbench

Multi-channel debug readout for the board's 8-digit seven-segment display. It selects one of `CHANNELS` debug words, converts it to decimal with a sequential double-dabble engine (or passes it through as hex), and time-multiplexes the digits onto `SEG`/`AN`/`DP`. It sits beside the CPU core in the top-level wrapper. It replaces the combinational binary-to-BCD path plus fixed scanner with one parametrised, clocked block.

---
 rtl/debug_seg_display.sv | 136 +++++++++++++
 tb/tb_debug_seg_display.sv | 136 +++++++++++++
 2 files changed

// File: rtl/debug_seg_display.sv
// debug_seg_display: channel-select, double-dabble/hex conversion and 7-seg scan; define DEBUG_SEG_LZB_EN for leading-zero blanking
module debug_seg_display #(
  parameter int WIDTH = 32,
  parameter int DIGITS = 8,
  parameter int CHANNELS = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [CHANNELS*WIDTH-1:0]                     ch_data,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  input  logic                                          mode,
  input  logic                                          freeze,
  output logic [6:0]                                    SEG,
  output logic [DIGITS-1:0]                             AN,
  output logic                                          DP,
  output logic                                          busy
);
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ND = (WIDTH + 2) / 3;
  localparam int BW = 4 * ND;
  localparam int DW = 4 * DIGITS;
  localparam int XW = (BW > DW) ? BW : DW;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0] r_bcd, w_adj;
  logic [CW-1:0] r_cnt;
  logic r_mode, r_ovf, r_seen_unused;
  logic [SW-1:0] r_ch, r_disp_ch, w_sel;
  logic [DW-1:0] r_disp;
  logic [XW-1:0] w_val;
  logic w_ovf;
  logic [RW-1:0] r_refresh;
  logic [IW-1:0] r_idx;
  logic [3:0] w_nib;
  logic [DIGITS-1:0] w_blank;
  logic [6:0] r_seg;
  logic [DIGITS-1:0] r_an;
  logic r_dp;
  assign w_sel = (32'(ch_sel) < CHANNELS) ? ch_sel : '0;
  assign w_val = r_mode ? XW'(r_bin) : XW'(r_bcd);
  assign w_ovf = |(w_val >> DW);
  assign w_nib = r_disp[4*r_idx +: 4];
  assign busy = r_state != IDLE;
  assign SEG = r_seg;
  assign AN = r_an;
  assign DP = r_dp;
  assign r_seen_unused = 1'b0;
  // converter next state: hex skips SHIFT, decimal runs WIDTH iterations
  always_comb begin
    w_next = (r_state == IDLE)  ? (freeze ? IDLE : LOAD) :
             (r_state == LOAD)  ? (mode ? DONE : SHIFT) :
             (r_state == SHIFT) ? ((r_cnt == CW'(WIDTH - 1)) ? DONE : SHIFT) : IDLE;
  end
  // double-dabble correction: add 3 to every BCD nibble of 5 or more before shifting
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < ND; d++) w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3 : r_bcd[4*d +: 4];
  end
`ifdef DEBUG_SEG_LZB_EN
  logic w_seen;
  // blank every digit above the most significant nonzero one; digit 0 always shows
  always_comb begin
    w_blank = '0;
    w_seen = 1'b0;
    for (int d = DIGITS - 1; d > 0; d--) begin
      w_seen = w_seen | (r_disp[4*d +: 4] != 4'd0);
      w_blank[d] = ~w_seen;
    end
  end
`else
  assign w_blank = '0;
`endif
  // converter datapath; display register only written whole in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_mode <= 1'b0;
      r_ch <= '0;
      r_disp <= '0;
      r_ovf <= 1'b0;
      r_disp_ch <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD) begin
        r_bin <= ch_data[w_sel*WIDTH +: WIDTH];
        r_bcd <= '0;
        r_cnt <= '0;
        r_mode <= mode;
        r_ch <= w_sel;
      end
      if (r_state == SHIFT) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == DONE) begin
        r_disp <= w_val[DW-1:0];
        r_ovf <= w_ovf;
        r_disp_ch <= r_ch;
      end
    end
  end
  // refresh divider and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx <= '0;
    end else if (r_refresh == RW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end
  // registered segment, anode and decimal-point drive for the current digit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= 7'h7F;
      r_an <= '1;
      r_dp <= 1'b1;
    end else begin
      r_seg <= w_blank[r_idx] ? 7'h7F : GLYPH[w_nib];
      r_an <= ~(DIGITS'(1) << r_idx);
      r_dp <= ~(r_ovf | (32'(r_disp_ch) == 32'(r_idx)));
    end
  end
endmodule

// File: tb/tb_debug_seg_display.sv
// tb_debug_seg_display: scoreboard bench for debug_seg_display (WIDTH=32, DIGITS=8, CHANNELS=3)
module tb_debug_seg_display;
  logic clk, reset, mode, freeze, DP, busy;
  logic [95:0] ch_data;
  logic [1:0] ch_sel;
  logic [6:0] SEG;
  logic [7:0] AN;
  int n_checks = 0;
  int n_err = 0;
  typedef struct packed {logic [55:0] seg; logic [7:0] dp;} exp_t;
  exp_t exp_q[$];
`ifdef DEBUG_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  debug_seg_display #(.WIDTH(32), .DIGITS(8), .CHANNELS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_sel(ch_sel), .mode(mode),
    .freeze(freeze), .SEG(SEG), .AN(AN), .DP(DP), .busy(busy));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [6:0] glyph(int n);
    case (n)
      0: return ~7'h3F;  1: return ~7'h06;  2: return ~7'h5B;  3: return ~7'h4F;
      4: return ~7'h66;  5: return ~7'h6D;  6: return ~7'h7D;  7: return ~7'h07;
      8: return ~7'h7F;  9: return ~7'h6F;  10: return ~7'h77; 11: return ~7'h7C;
      12: return ~7'h39; 13: return ~7'h5E; 14: return ~7'h79; default: return ~7'h71;
    endcase
  endfunction
  function automatic exp_t model(logic [31:0] v, bit hex, int ch);
    exp_t e;
    longint unsigned x = 64'(v);
    int nib[8];
    int top = 0;
    bit ovf = !hex && (x >= 64'd100000000);
    for (int i = 0; i < 8; i++) begin
      nib[i] = hex ? int'((v >> (4*i)) & 32'hF) : int'(x % 10);
      x = x / 10;
      if (nib[i] != 0) top = i;
    end
    for (int i = 0; i < 8; i++) begin
      e.seg[7*i +: 7] = (LZB && i > top) ? 7'h7F : glyph(nib[i]);
      e.dp[i] = !(ovf || i == ch);
    end
    return e;
  endfunction
  task automatic compare_sweep(string tag);
    exp_t g, e;
    logic [7:0] seen;
    g = '0;
    seen = '0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        if (AN === ~(8'd1 << i)) begin
          g.seg[7*i +: 7] = SEG;
          g.dp[i] = DP;
          seen[i] = 1'b1;
        end
    end
    check({tag, " an_sweep"}, 64'(seen), 64'hFF);
    e = exp_q.pop_front();
    for (int i = 0; i < 8; i++) check($sformatf("%s seg%0d", tag, i), 64'(g.seg[7*i +: 7]), 64'(e.seg[7*i +: 7]));
    check({tag, " dp"}, 64'(g.dp), 64'(e.dp));
  endtask
  task automatic run(string tag, int ch, logic [31:0] v, logic [1:0] sel, bit hex);
    ch_data[32*ch +: 32] = v;
    ch_sel = sel;
    mode = hex;
    exp_q.push_back(model(v, hex, (int'(sel) < 3) ? int'(sel) : 0));
    repeat (75) @(negedge clk);
    compare_sweep(tag);
  endtask
  initial begin
    int hi, t;
    reset = 1'b1; ch_data = '0; ch_sel = '0; mode = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst seg", 64'(SEG), 64'h7F);
    check("rst an", 64'(AN), 64'hFF);
    check("rst dp", 64'(DP), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("post an", 64'(AN), 64'hFE);
    check("post seg", 64'(SEG), 64'h40);
    check("post dp", 64'(DP), 64'd0);
    run("dec12345678", 0, 32'd12345678, 2'd0, 1'b0);
    hi = 0;
    for (int c = 0; c < 70; c++) begin @(negedge clk); hi += int'(busy); end
    check("busy dec", 64'(hi), 64'd68);
    run("hexdeadbeef", 2, 32'hDEADBEEF, 2'd2, 1'b1);
    hi = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); hi += int'(busy); end
    check("busy hex", 64'(hi), 64'd20);
    run("ovf", 0, 32'd4294967295, 2'd0, 1'b0);
    run("sel_oor305", 0, 32'd305, 2'd3, 1'b0);
    run("zero_ch1", 1, 32'd0, 2'd1, 1'b1);
    run("x42", 0, 32'h42, 2'd0, 1'b0);
    freeze = 1'b1;
    repeat (40) @(negedge clk);
    ch_data[31:0] = 32'd7;
    exp_q.push_back(model(32'h42, 1'b0, 0));
    repeat (80) @(negedge clk);
    check("frozen idle", 64'(busy), 64'd0);
    compare_sweep("frozen");
    freeze = 1'b0;
    exp_q.push_back(model(32'd7, 1'b0, 0));
    repeat (37) @(negedge clk);
    compare_sweep("thaw");
    ch_data[31:0] = 32'd12345678;
    repeat (75) @(negedge clk);
    t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    while (busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("busy rise in bound", 64'(t < 100), 64'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst seg", 64'(SEG), 64'h7F);
    check("midrst an", 64'(AN), 64'hFF);
    reset = 1'b0;
    @(negedge clk);
    check("midrst scan an", 64'(AN), 64'hFE);
    check("midrst scan seg", 64'(SEG), 64'h40);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
